// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through FIFO controller in front of an external 1R/1W block RAM.
// Pushes write straight through BRAM port B; port A prefetches into a 2-entry
// output buffer so the head is always registered and a pop can happen every cycle.
// Optional feature: define BRAM_FIFO_ERR_EN to add a sticky o_error port.
module bram_fifo_ctrl #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned ADDR_LSH = 2
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic                     o_full,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_rdata,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH)+1:0] o_count,
  output logic                     o_pa_request,
  output logic [31:0]              o_pa_address,
  input  logic [WIDTH-1:0]         i_pa_rdata,
  input  logic                     i_pa_ready,
  output logic                     o_pb_request,
  output logic [31:0]              o_pb_address,
  output logic [WIDTH-1:0]         o_pb_wdata,
`ifdef BRAM_FIFO_ERR_EN
  output logic                     o_error,
`endif
  input  logic                     i_pb_ready
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      mem_count_q, mem_count_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       buf_cnt_q, buf_cnt_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;
  logic [AW+1:0]    count_q, count_d;

  logic             push_acc;
  logic             pop_acc;
  logic             rd_issue;
  logic             capture;
  logic [2:0]       occ_after_pop;
  logic [1:0]       cnt_after_pop;

  // Handshakes, read-issue decision and BRAM port drive
  always_comb begin
    o_full        = (mem_count_q == (AW+1)'(DEPTH));
    o_valid       = (buf_cnt_q != 2'd0);
    o_rdata       = buf0_q;
    o_count       = count_q;
    push_acc      = i_push & ~o_full;
    pop_acc       = i_pop & o_valid;
    capture       = inflight_q & i_pa_ready;
    // Words already headed for the buffer once this cycle's pop is taken out
    occ_after_pop = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_acc};
    rd_issue      = (mem_count_q != '0) & (occ_after_pop < 3'd2);
    o_pb_request  = push_acc;
    o_pb_address  = 32'(wr_ptr_q) << ADDR_LSH;
    o_pb_wdata    = i_wdata;
    o_pa_request  = rd_issue;
    o_pa_address  = 32'(rd_ptr_q) << ADDR_LSH;
  end

  // Next-state for pointers, occupancy and the output buffer
  always_comb begin
    wr_ptr_d    = wr_ptr_q + AW'(push_acc);
    rd_ptr_d    = rd_ptr_q + AW'(rd_issue);
    mem_count_d = mem_count_q + (AW+1)'(push_acc) - (AW+1)'(rd_issue);
    inflight_d  = rd_issue | (inflight_q & ~i_pa_ready);

    buf0_d        = buf0_q;
    buf1_d        = buf1_q;
    cnt_after_pop = buf_cnt_q - {1'b0, pop_acc};
    if (pop_acc) begin
      buf0_d = buf1_q;
    end
    // Returned word lands at the first free slot after the pop shift
    if (capture) begin
      if (cnt_after_pop == 2'd0) begin
        buf0_d = i_pa_rdata;
      end else begin
        buf1_d = i_pa_rdata;
      end
    end
    buf_cnt_d = cnt_after_pop + {1'b0, capture};

    count_d = (AW+2)'(mem_count_d) + (AW+2)'(inflight_d) + (AW+2)'(buf_cnt_d);
  end

  // State registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      inflight_q  <= 1'b0;
      buf_cnt_q   <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      count_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      inflight_q  <= inflight_d;
      buf_cnt_q   <= buf_cnt_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      count_q     <= count_d;
    end
  end

`ifdef BRAM_FIFO_ERR_EN
  logic err_q, err_d;
  logic pb_pend_q;

  // Sticky error: illegal push/pop, or a write that was not acked the next cycle
  always_comb begin
    err_d   = err_q | (i_push & o_full) | (i_pop & ~o_valid) | (pb_pend_q & ~i_pb_ready);
    o_error = err_q;
  end

  // Error flag and pending-write tracker
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      err_q     <= 1'b0;
      pb_pend_q <= 1'b0;
    end else begin
      err_q     <= err_d;
      pb_pend_q <= o_pb_request;
    end
  end
`else
  // Write ack only matters to the error check
  logic unused_pb_ready;
  assign unused_pb_ready = i_pb_ready;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: BRAM model, queue-based reference model checked every
// cycle on the falling edge, plus directed scenarios with literal expectations.
module tb_bram_fifo_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 8;
  localparam int unsigned AW = 3;

  logic          clk;
  logic          rst_n;
  logic          push;
  logic [W-1:0]  wdata;
  logic          full;
  logic          valid;
  logic [W-1:0]  rdata;
  logic          pop;
  logic [AW+1:0] count;
  logic          pa_req;
  logic [31:0]   pa_addr;
  logic [W-1:0]  pa_rdata;
  logic          pa_ready;
  logic          pb_req;
  logic [31:0]   pb_addr;
  logic [W-1:0]  pb_wdata;
  logic          pb_ready;
`ifdef BRAM_FIFO_ERR_EN
  logic          err;
`endif

  int checks = 0;
  int errors = 0;

  bram_fifo_ctrl #(
    .WIDTH   (W),
    .DEPTH   (D),
    .ADDR_LSH(2)
  ) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_push      (push),
    .i_wdata     (wdata),
    .o_full      (full),
    .o_valid     (valid),
    .o_rdata     (rdata),
    .i_pop       (pop),
    .o_count     (count),
    .o_pa_request(pa_req),
    .o_pa_address(pa_addr),
    .i_pa_rdata  (pa_rdata),
    .i_pa_ready  (pa_ready),
    .o_pb_request(pb_req),
    .o_pb_address(pb_addr),
    .o_pb_wdata  (pb_wdata),
`ifdef BRAM_FIFO_ERR_EN
    .o_error     (err),
`endif
    .i_pb_ready  (pb_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous BRAM: 1-cycle registered read, write acked the following cycle
  logic [W-1:0] bram [D];
  always @(posedge clk) begin
    if (pb_req) bram[pb_addr[2 +: AW]] <= pb_wdata;
    pa_rdata <= bram[pa_addr[2 +: AW]];
    pa_ready <= pa_req;
    pb_ready <= pb_req;
  end

  // Reference model: words in memory, one word on the read bus, and the output buffer
  logic [W-1:0] m_mem[$];
  logic [W-1:0] m_buf[$];
  bit           f_v;
  logic [W-1:0] f_d;
  int           wr_n;
  int           rd_n;
  bit           m_err;
  bit           pb_prev;

  // Compare DUT against the model each cycle, then advance the model
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", valid, 0);
      check("rst_count", count, 0);
      check("rst_full", full, 0);
      check("rst_pa_req", pa_req, 0);
`ifdef BRAM_FIFO_ERR_EN
      check("rst_error", err, 0);
`endif
      m_mem.delete();
      m_buf.delete();
      f_v = 0; wr_n = 0; rd_n = 0; m_err = 0; pb_prev = 0;
    end else begin
      bit exp_full, exp_valid, acc_push, acc_pop, iss;
      int exp_count;
      exp_full  = (m_mem.size() == D);
      exp_valid = (m_buf.size() > 0);
      exp_count = m_mem.size() + int'(f_v) + m_buf.size();
      acc_push  = push && !exp_full;
      acc_pop   = pop && exp_valid;
      iss       = (m_mem.size() > 0) && (m_buf.size() + int'(f_v) - int'(acc_pop) < 2);

      check("full", full, exp_full);
      check("valid", valid, exp_valid);
      check("count", count, exp_count);
      if (exp_valid) check("rdata", rdata, m_buf[0]);
      check("pb_req", pb_req, acc_push);
      check("pb_addr", pb_addr, wr_n << 2);
      if (acc_push) check("pb_wdata", pb_wdata, wdata);
      check("pa_req", pa_req, iss);
      check("pa_addr", pa_addr, rd_n << 2);
`ifdef BRAM_FIFO_ERR_EN
      check("error", err, m_err);
      m_err   = m_err | (push && exp_full) | (pop && !exp_valid) | (pb_prev && !pb_ready);
      pb_prev = acc_push;
`endif

      if (acc_pop) void'(m_buf.pop_front());
      if (f_v && pa_ready) begin
        m_buf.push_back(f_d);
        f_v = 0;
      end
      if (iss) begin
        f_d  = m_mem.pop_front();
        f_v  = 1;
        rd_n = (rd_n + 1) % D;
      end
      if (acc_push) begin
        m_mem.push_back(wdata);
        wr_n = (wr_n + 1) % D;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single word: write in cycle 0, read issue cycle 1, valid in cycle 3
    push = 1'b1; wdata = 32'hA5;
    @(negedge clk);
    check("t1_pb_req", pb_req, 1);
    check("t1_pb_addr", pb_addr, 0);
    next_cycle();
    push = 1'b0;
    @(negedge clk);
    check("t1_pa_req", pa_req, 1);
    next_cycle();
    @(negedge clk);
    check("t1_valid_c2", valid, 0);
    next_cycle();
    @(negedge clk);
    check("t1_valid_c3", valid, 1);
    check("t1_rdata", rdata, 32'hA5);
    check("t1_count", count, 1);
    pop = 1'b1;
    next_cycle();
    pop = 1'b0;
    @(negedge clk);
    check("t1_empty", valid, 0);

    // Burst of 1..8 then a continuous pop with no bubbles
    next_cycle();
    for (int k = 1; k <= 8; k++) begin
      push = 1'b1; wdata = k;
      next_cycle();
    end
    push = 1'b0;
    repeat (3) next_cycle();
    for (int k = 1; k <= 8; k++) begin
      pop = 1'b1;
      @(negedge clk);
      check("t2_valid", valid, 1);
      check("t2_rdata", rdata, k);
      next_cycle();
    end
    pop = 1'b0;
    @(negedge clk);
    check("t2_drained", valid, 0);

    // Fill past capacity: DEPTH+2 held, extra pushes refused
    next_cycle();
    for (int i = 0; i < D + 5; i++) begin
      push = 1'b1; wdata = $urandom;
      next_cycle();
    end
    @(negedge clk);
    check("t3_full", full, 1);
    check("t3_pb_req", pb_req, 0);
    check("t3_count", count, D + 2);
    next_cycle();
    push = 1'b0;
    pop  = 1'b1;
    repeat (D + 4) next_cycle();
    pop = 1'b0;

    // Pop on empty: ignored, flags an error only in the error build
    pop = 1'b1;
    next_cycle();
    pop = 1'b0;
    @(negedge clk);
    check("t6_valid", valid, 0);
    check("t6_count", count, 0);
`ifdef BRAM_FIFO_ERR_EN
    check("t6_error", err, 1);
    repeat (3) next_cycle();
    @(negedge clk);
    check("t6_error_sticky", err, 1);
`endif

    // Streaming push+pop across several pointer wraps
    next_cycle();
    for (int i = 0; i < 3 * D; i++) begin
      push = 1'b1; pop = 1'b1; wdata = $urandom;
      next_cycle();
    end
    push = 1'b0;
    repeat (D + 4) next_cycle();
    pop = 1'b0;

    // Reset while a read is on the bus, then a clean write/read
    push = 1'b1; wdata = 32'h5A;
    next_cycle();
    push = 1'b0;
    @(negedge clk);
    check("t5_pa_req", pa_req, 1);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_valid", valid, 0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_valid", valid, 0);
    check("t5_count", count, 0);
    next_cycle();
    push = 1'b1; wdata = 32'h77;
    next_cycle();
    push = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("t5_rd_valid", valid, 1);
    check("t5_rd_data", rdata, 32'h77);
    next_cycle();

    // Randomized traffic in biased phases to reach full, empty and steady state
    for (int ph = 0; ph < 4; ph++) begin
      int unsigned push_pct, pop_pct;
      push_pct = (ph == 0) ? 80 : (ph == 1) ? 20 : (ph == 2) ? 50 : 95;
      pop_pct  = (ph == 0) ? 30 : (ph == 1) ? 80 : (ph == 2) ? 50 : 95;
      for (int i = 0; i < 300; i++) begin
        push  = ($urandom_range(0, 99) < push_pct);
        pop   = ($urandom_range(0, 99) < pop_pct);
        wdata = $urandom;
        next_cycle();
      end
    end
    push = 1'b0;
    pop  = 1'b0;
    repeat (4) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
